regfile_wb_arbiter: RTL and testbench

Owns the single write port of the 64x32 register file. It shares that port between two writeback sources:
- A: the main ALU writeback path.
- B: the long-latency load/multiply path.
Arbitration is fixed priority with anti-starvation for B. After reset, the block sequences a hardware clear of every register before it accepts any writeback traffic.

---
 rtl/regfile_wb_arbiter_if.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 88 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two sources (A: ALU, B: load/multiply) and the
// register-file write-port arbiter, including the registered write port itself.
interface regfile_wb_arbiter_if #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 32
);
   // Handshake: a source raises valid with stable addr/data and holds them until
   // it sees ready high in the same cycle; that cycle is the transfer. Valid never
   // depends on ready, and ready is only ever high while the arbiter is in RUN.
   logic              a_valid;
   logic              a_ready;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              b_valid;
   logic              b_ready;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              init_busy;

   modport master (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata, init_busy
   );

   modport slave (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
      output a_ready, b_ready, rf_we, rf_waddr, rf_wdata, init_busy
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: clears all registers after reset, then arbitrates
// A (priority) against B with starvation relief. Optional macro: R0_HARDWIRE_EN.
module regfile_wb_arbiter #(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 32,
   parameter int NUM_REGS   = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic       clk,
   input  logic       reset,
   regfile_wb_arbiter_if.slave wb,
   output logic [0:0] state_dbg
);
   localparam int SW = $clog2(STARVE_MAX + 1);

   localparam logic [0:0] S_INIT = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]        state;
   logic [ADDR_W-1:0] cnt;
   logic [SW-1:0]     starve;
   logic              grant_a;
   logic              grant_b;
   logic              xfer;
   logic              wr_en_run;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (state == S_RUN) begin
         if (wb.a_valid && !(wb.b_valid && starve == SW'(STARVE_MAX)))
            grant_a = 1'b1;
         else if (wb.b_valid)
            grant_b = 1'b1;
      end
   end

   assign xfer     = grant_a | grant_b;
   assign sel_addr = grant_b ? wb.b_addr : wb.a_addr;
   assign sel_data = grant_b ? wb.b_data : wb.a_data;

`ifdef R0_HARDWIRE_EN
   // Address-0 transfers complete normally but never reach the register file.
   assign wr_en_run = xfer && (sel_addr != '0);
`else
   assign wr_en_run = xfer;
`endif

   assign wb.a_ready  = grant_a;
   assign wb.b_ready  = grant_b;
   assign wb.init_busy = (state == S_INIT);
   assign state_dbg   = state;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_INIT;
         cnt         <= '0;
         starve      <= '0;
         wb.rf_we    <= 1'b0;
         wb.rf_waddr <= '0;
         wb.rf_wdata <= '0;
      end else if (state == S_INIT) begin
         wb.rf_we    <= 1'b1;
         wb.rf_waddr <= cnt;
         wb.rf_wdata <= '0;
         starve      <= '0;
         if (cnt == ADDR_W'(NUM_REGS - 1)) begin
            state <= S_RUN;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         wb.rf_we <= wr_en_run;
         if (wr_en_run) begin
            wb.rf_waddr <= sel_addr;
            wb.rf_wdata <= sel_data;
         end
         // A waiting B ages toward a forced win; any grant or withdrawal resets it.
         if (wb.b_valid && !grant_b)
            starve <= (starve == SW'(STARVE_MAX)) ? starve : starve + 1'b1;
         else
            starve <= '0;
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: clear sequence, priority/starvation grants,
// reset abort, address-0 handling (R0_HARDWIRE_EN aware) and a held-request random phase.
module tb_regfile_wb_arbiter;
   localparam int ADDR_W     = 6;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 64;
   localparam int STARVE_MAX = 4;
   localparam int EW         = 1 + ADDR_W + DATA_W;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [0:0] state_dbg;

   regfile_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb ();

   regfile_wb_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk),
      .reset(reset),
      .wb(wb),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [EW-1:0]     exp_q[$];
   int                m_starve;
   logic [ADDR_W-1:0] last_addr;
   logic [DATA_W-1:0] last_data;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                        input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd);
      wb.a_valid = av; wb.a_addr = aa; wb.a_data = ad;
      wb.b_valid = bv; wb.b_addr = ba; wb.b_data = bd;
   endtask

   // One RUN cycle: called just after a rising edge, returns just after the next one.
   task automatic step(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                       input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                       output logic ra, output logic rb);
      logic ga, gb, we;
      logic [ADDR_W-1:0] wa;
      logic [DATA_W-1:0] wd;
      logic [EW-1:0] e;
      drive(av, aa, ad, bv, ba, bd);
      @(negedge clk);
      ga = av && !(bv && m_starve == STARVE_MAX);
      gb = bv && !ga;
      ra = wb.a_ready;
      rb = wb.b_ready;
      chk("a_ready", 64'(ra), 64'(ga));
      chk("b_ready", 64'(rb), 64'(gb));
      chk("one_ready", 64'(ra && rb), 64'(0));
      we = ga || gb;
      wa = gb ? ba : aa;
      wd = gb ? bd : ad;
`ifdef R0_HARDWIRE_EN
      if (wa == '0) we = 1'b0;
`endif
      if (we) begin
         last_addr = wa;
         last_data = wd;
      end
      exp_q.push_back({we, last_addr, last_data});
      if (bv && !gb) m_starve = (m_starve == STARVE_MAX) ? m_starve : m_starve + 1;
      else m_starve = 0;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("rf_we", 64'(wb.rf_we), 64'(e[EW-1]));
      chk("rf_waddr", 64'(wb.rf_waddr), 64'(e[EW-2 -: ADDR_W]));
      chk("rf_wdata", 64'(wb.rf_wdata), 64'(e[DATA_W-1:0]));
   endtask

   // Releases reset and follows the clear sequence; abort_at >= 0 reasserts reset
   // right after the write to that address is seen.
   task automatic run_init(input int abort_at);
      reset = 1'b1;
      drive(1'b1, 6'd9, 32'h1111_2222, 1'b1, 6'd17, 32'h3333_4444);
      for (int i = 0; i < NUM_REGS; i++) begin
         @(posedge clk);
         #1;
         chk("init_we", 64'(wb.rf_we), 64'(1));
         chk("init_waddr", 64'(wb.rf_waddr), 64'(i));
         chk("init_wdata", 64'(wb.rf_wdata), 64'(0));
         chk("init_busy", 64'(wb.init_busy), 64'(i < NUM_REGS - 1));
         if (i < NUM_REGS - 1)
            chk("init_readies", 64'({wb.a_ready, wb.b_ready}), 64'(0));
         if (i == NUM_REGS - 3)
            drive(1'b0, '0, '0, 1'b0, '0, '0);
         if (i == abort_at) begin
            reset = 1'b0;
            @(posedge clk);
            #1;
            chk("abort_we", 64'(wb.rf_we), 64'(0));
            chk("abort_busy", 64'(wb.init_busy), 64'(1));
            chk("abort_readies", 64'({wb.a_ready, wb.b_ready}), 64'(0));
            break;
         end
      end
      if (abort_at < 0) begin
         chk("run_readies_idle", 64'({wb.a_ready, wb.b_ready}), 64'(0));
         m_starve  = 0;
         last_addr = ADDR_W'(NUM_REGS - 1);
         last_data = '0;
      end
   endtask

   initial begin
      logic ra, rb, pa, pb;
      logic [ADDR_W-1:0] aa, ba;
      logic [DATA_W-1:0] ad, bd;
      int denials;

      drive(1'b0, '0, '0, 1'b0, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_we", 64'(wb.rf_we), 64'(0));
      chk("rst_waddr", 64'(wb.rf_waddr), 64'(0));
      chk("rst_wdata", 64'(wb.rf_wdata), 64'(0));
      chk("rst_busy", 64'(wb.init_busy), 64'(1));
      chk("rst_state", 64'(state_dbg), 64'(0));
      run_init(-1);

      // Single A write, then an idle cycle.
      step(1'b1, 6'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, ra, rb);
      chk("t2_a_ready", 64'(ra), 64'(1));
      step(1'b0, '0, '0, 1'b0, '0, '0, ra, rb);
      chk("t2_idle_we", 64'(wb.rf_we), 64'(0));

      // Both requesting: A,A,A,A,B repeating.
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 6'(10 + i), 32'(32'hA000_0000 + i), 1'b1, 6'(40 + i), 32'(32'hB000_0000 + i), ra, rb);
         chk("t3_grant_b", 64'(rb), 64'(i % 5 == 4));
      end
      step(1'b0, '0, '0, 1'b0, '0, '0, ra, rb);

      // Address 0 from A.
      step(1'b1, 6'd0, 32'h1234_5678, 1'b0, '0, '0, ra, rb);
      chk("t5_a_ready", 64'(ra), 64'(1));
`ifdef R0_HARDWIRE_EN
      chk("t5_r0_we", 64'(wb.rf_we), 64'(0));
`else
      chk("t5_r0_we", 64'(wb.rf_we), 64'(1));
      chk("t5_r0_data", 64'(wb.rf_wdata), 64'(32'h1234_5678));
`endif

      // B held on r63 while A toggles.
      denials = 0;
      for (int i = 0; i < 16; i++) begin
         pa = (i % 2 == 0);
         step(pa, 6'(20 + i), 32'(32'hC000_0000 + i), 1'b1, 6'd63, 32'hBBBB_0063, ra, rb);
         if (!pa) chk("t6_b_when_a_idle", 64'(rb), 64'(1));
         denials = rb ? 0 : denials + 1;
         chk("t6_denial_bound", 64'(denials <= STARVE_MAX), 64'(1));
      end
      step(1'b0, '0, '0, 1'b0, '0, '0, ra, rb);

      // Random requests, each held until accepted.
      pa = 1'b0; pb = 1'b0;
      aa = '0; ad = '0; ba = '0; bd = '0;
      ra = 1'b1; rb = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (!pa || ra) begin
            pa = 1'($urandom_range(0, 3) != 0);
            aa = 6'($urandom_range(0, 63));
            ad = $urandom;
         end
         if (!pb || rb) begin
            pb = 1'($urandom_range(0, 1));
            ba = 6'($urandom_range(0, 63));
            bd = $urandom;
         end
         step(pa, aa, ad, pb, ba, bd, ra, rb);
      end
      step(1'b0, '0, '0, 1'b0, '0, '0, ra, rb);

      // Reset in the middle of the clear, then a full clear and one write.
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      run_init(29);
      repeat (2) @(posedge clk);
      #1;
      run_init(-1);
      step(1'b0, '0, '0, 1'b1, 6'd33, 32'h0BAD_F00D, ra, rb);
      chk("final_b_ready", 64'(rb), 64'(1));
      step(1'b0, '0, '0, 1'b0, '0, '0, ra, rb);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      fails++;
      $display("FAIL timeout observed=running expected=finished");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
